// File: rtl/decryptor_stream_if.sv
// Cipher link handshake bundle: ciphertext in, plaintext out.
// The master side drives the input byte and the output ready.
// The slave side (the decryptor) drives everything else.
interface decryptor_stream_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_code;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_char;
    logic       out_err;
    logic       out_last;

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_char, out_err, out_last
    );

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_char, out_err, out_last
    );
endinterface

// File: rtl/decryptor_stream.sv
// Streaming Polybius/Nihilist decryptor.
// For each accepted byte, the running key number is subtracted from the byte.
// The difference is split into row/col digits and looked up in the fixed 5x5 square.
// One output register stage holds the result; a 2-state FSM tracks whether it is occupied.
module decryptor_stream #(
    parameter int MSG_LEN = 6,
    parameter int SEC_LEN = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    decryptor_stream_if.slave   bus
);

    localparam int CW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int KW = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1;
    localparam logic [CW-1:0] CHAR_MAX = CW'(MSG_LEN - 1);
    localparam logic [KW-1:0] KEY_MAX  = KW'(SEC_LEN - 1);

    // Square laid out row-major, rows 1..5 and columns 1..5 mapped to index 0..24.
    localparam logic [7:0] SQUARE [0:24] = '{
        "M", "I", "H", "A", "B",
        "C", "D", "E", "F", "G",
        "K", "L", "N", "O", "P",
        "Q", "R", "S", "T", "U",
        "V", "W", "X", "Y", "Z"
    };

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_char_idx;
    logic [KW-1:0]   r_key_idx;
    logic [7:0]      r_char_p1;
    logic            r_err_p1;
    logic            r_last_p1;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_char_wrap;
    logic [8:0]      w_dec;

    // The secret "KEY" repeats every three characters: K=31, E=23, Y=54.
    function automatic logic [7:0] key_num(input int unsigned idx);
        case (idx % 3)
            0:       key_num = 8'd31;
            1:       key_num = 8'd23;
            default: key_num = 8'd54;
        endcase
    endfunction

    // Returns {err, char}. A subtraction that would underflow is an error.
    // Any digit outside 1..5 is also an error; there is no modular wrap.
    function automatic logic [8:0] decode(input logic [7:0] code, input logic [7:0] key);
        logic [7:0] diff;
        logic [7:0] row;
        logic [7:0] col;
        logic [7:0] sq_idx;
        diff   = code - key;
        row    = diff / 8'd10;
        col    = diff % 8'd10;
        sq_idx = (row - 8'd1) * 8'd5 + (col - 8'd1);
        if (code < key)
            decode = {1'b1, 8'h3F};
        else if (row >= 8'd1 && row <= 8'd5 && col >= 8'd1 && col <= 8'd5)
            decode = {1'b0, SQUARE[sq_idx[4:0]]};
        else
            decode = {1'b1, 8'h3F};
    endfunction

    assign w_in_ready  = (r_state == S_EMPTY) || bus.out_ready;
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_char_wrap = (r_char_idx == CHAR_MAX);
    assign w_dec       = decode(bus.in_code, key_num(int'(unsigned'(r_key_idx))));

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == S_FULL);
    assign bus.out_char  = r_char_p1;
    assign bus.out_err   = r_err_p1;
    assign bus.out_last  = r_last_p1;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_EMPTY;
        else
            r_state <= w_state_nxt;
    end

    // Next state: fill on accept; empty on a consume that has no refill.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
            S_FULL:  if (bus.out_ready && !w_accept) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // Position counters: the key index restarts whenever a message ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_char_idx <= '0;
            r_key_idx  <= '0;
        end else if (w_accept) begin
            if (w_char_wrap) begin
                r_char_idx <= '0;
                r_key_idx  <= '0;
            end else begin
                r_char_idx <= r_char_idx + 1'b1;
                r_key_idx  <= (r_key_idx == KEY_MAX) ? '0 : r_key_idx + 1'b1;
            end
        end
    end

    // Stage p1 output register: loads only on accept, so it holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_char_p1 <= 8'h00;
            r_err_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
        end else if (w_accept) begin
            r_char_p1 <= w_dec[7:0];
            r_err_p1  <= w_dec[8];
            r_last_p1 <= w_char_wrap;
        end
    end

endmodule

// File: tb/tb_decryptor_stream.sv
// Scoreboard bench for decryptor_stream using directed ciphertext vectors.
module tb_decryptor_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc_used = 0;
    logic [9:0] exp_q [$];

    decryptor_stream_if bus ();

    decryptor_stream #(.MSG_LEN(6), .SEC_LEN(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare each beat the downstream takes against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {22'd0, bus.out_char, bus.out_err, bus.out_last}, 32'h3ff);
                end else begin
                    chk("out_beat", {22'd0, bus.out_char, bus.out_err, bus.out_last},
                        {22'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] code, input logic [7:0] ch, input logic e, input logic l);
        int  n;
        logic acc;
        n = 0;
        acc = 1'b0;
        exp_q.push_back({ch, e, l});
        bus.in_valid = 1'b1;
        bus.in_code  = code;
        while (!acc && n < 50) begin
            @(negedge clk);
            if (bus.in_ready) acc = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
        cyc_used += n;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_attack();
        send(8'd45, "A", 1'b0, 1'b0);
        send(8'd67, "T", 1'b0, 1'b0);
        send(8'd98, "T", 1'b0, 1'b0);
        send(8'd45, "A", 1'b0, 1'b0);
        send(8'd44, "C", 1'b0, 1'b0);
        send(8'd85, "K", 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_code   = 8'd0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_char", bus.out_char, 8'h00);
        chk("rst_out_err", bus.out_err, 1'b0);
        chk("rst_out_last", bus.out_last, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);

        // Known message, full rate.
        cyc_used = 0;
        send_attack();
        chk("attack_cycles", cyc_used, 32'd6);
        drain();

        // Backpressure: first output held for three cycles.
        do_reset();
        fork
            send_attack();
            begin
                int n;
                n = 0;
                while (!bus.out_valid && n < 20) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                chk("bp_first_valid", bus.out_valid, 1'b1);
                bus.out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("bp_hold_char", bus.out_char, "A");
                    chk("bp_in_ready", bus.in_ready, 1'b0);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Error codes.
        do_reset();
        send(8'd20,  8'h3F, 1'b1, 1'b0);
        send(8'd40,  8'h3F, 1'b1, 1'b0);
        send(8'd42,  8'h3F, 1'b1, 1'b0);
        send(8'd42,  "M",   1'b0, 1'b0);
        send(8'd255, 8'h3F, 1'b1, 1'b0);
        send(8'd85,  "K",   1'b0, 1'b1);
        drain();

        // Two messages back to back; key restarts at K for the second.
        do_reset();
        send_attack();
        send(8'd62, "K", 1'b0, 1'b0);
        send(8'd67, "T", 1'b0, 1'b0);
        send(8'd98, "T", 1'b0, 1'b0);
        send(8'd45, "A", 1'b0, 1'b0);
        send(8'd44, "C", 1'b0, 1'b0);
        send(8'd85, "K", 1'b0, 1'b1);
        drain();

        // Reset mid-message.
        do_reset();
        send(8'd45, "A", 1'b0, 1'b0);
        send(8'd67, "T", 1'b0, 1'b0);
        send(8'd98, "T", 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1 chk("midrst_out_valid", bus.out_valid, 1'b0);
        exp_q.delete();
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'd45, "A", 1'b0, 1'b0);
        drain();

        // Corner letters at index 0.
        do_reset();
        send(8'd42, "M", 1'b0, 1'b0);
        drain();
        do_reset();
        send(8'd86, "Z", 1'b0, 1'b0);
        drain();
        do_reset();
        send(8'd41, 8'h3F, 1'b1, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decryptor_stream.md
Name: decryptor_stream

Overview:
- Streaming inverse of the team's Polybius/Nihilist encryptor. Accepts one ciphertext byte per handshake, subtracts the running key digit-pair and maps the result back through the fixed 5x5 substitution square to an ASCII letter.
- Sits at the receive end of the cipher link. Consumes encryptor output serially, one character per beat, and emits plaintext with message framing.

Parameters:
- MSG_LEN, 6: characters per message. Sets the key-index restart and out_last position.
- SEC_LEN, 3: key length. Key is fixed "K","E","Y" for SEC_LEN=3.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  ciphertext byte present
- in_ready  output  1  block can accept a byte this cycle
- in_code  input  8  ciphertext value (unsigned)
- out_valid  output  1  plaintext byte present
- out_ready  input  1  downstream accepts this cycle
- out_char  output  8  decoded ASCII letter, or "?" (8'h3F) on error
- out_err  output  1  current out_char came from an undecodable code
- out_last  output  1  current out_char is character MSG_LEN-1 of its message

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Square, fixed, rows and columns 1..5:
  - row 1: M I H A B
  - row 2: C D E F G
  - row 3: K L N O P
  - row 4: Q R S T U
  - row 5: V W X Y Z
  - No J.
- Position number of a letter = row*10 + col, e.g. K=31, E=23, Y=54.
- Key number for character index i = position(secret[i mod SEC_LEN]).
- Decode arithmetic, 8-bit unsigned:
  - diff = in_code - keynum. Error if in_code < keynum (no wrap-around allowed).
  - row = diff/10, col = diff%10. Valid only if row in 1..5 and col in 1..5. Otherwise error.
  - Valid: out_char = square[row][col], out_err=0. Error: out_char=8'h3F, out_err=1.
- Pipeline: a single output register, latency 1 cycle from the accepting edge to out_valid.
  - in_ready = !out_valid || out_ready (combinational). Accept means in_valid && in_ready.
  - Accept with out_ready high and out_valid high is a simultaneous consume and load. Back-to-back throughput is 1 byte/cycle.
  - While out_valid && !out_ready: out_char, out_err and out_last are held stable; in_ready=0.
  - out_valid falls on a consume with no simultaneous accept.
- Counters:
  - char_idx counts 0..MSG_LEN-1 and increments on each accept. At MSG_LEN-1 the next accept wraps it to 0.
  - key_idx counts 0..SEC_LEN-1 and increments on each accept. It wraps at SEC_LEN-1 and is forced to 0 whenever char_idx wraps, so every message restarts at key index 0.
  - out_last is registered with the data: 1 when the accepted byte had char_idx == MSG_LEN-1.
- Errors do not stall or resynchronise the counters. The next byte uses the next key index.
- FSM, 2 states:
  - EMPTY: out_valid=0. Goes to FULL on accept.
  - FULL: out_valid=1. Goes to EMPTY on consume with no accept; stays FULL on consume with accept or on stall.
- Reset values:
  - out_valid=0, out_char=8'h00, out_err=0, out_last=0, char_idx=0, key_idx=0, state EMPTY.
  - in_ready reads 1 after reset.
- Reset mid-message drops any held output and restarts the message at index 0. The next accepted byte decodes with key K.
- Input range: legal ciphertext is 22..110. Codes 0..21 and 111..255 always produce an error for some key. Each case is checked per the rule above, not by this range.

Test Plan:
- Known message: send 45,67,98,45,44,85 with out_ready=1 -> "A","T","T","A","C","K" at 1/cycle; out_err=0 throughout; out_last=1 only on "K".
- Backpressure: drive "ATTACK" codes with out_ready low for 3 cycles after the first output -> out_char="A" held, in_ready=0, no byte lost or duplicated, final sequence unchanged.
- Error codes: 20 at index 0 -> "?", out_err=1. 40 at index 1 -> diff=17, col 7 -> "?", out_err=1. 42 at index 2 -> underflow -> "?", out_err=1. Index 3 code 42 -> 11 -> "M", out_err=0.
- Two messages back-to-back: 12 codes -> second message key restarts at K; code 62 at index 6 -> 31 -> "K"; out_last on indices 5 and 11.
- Reset mid-message: after 3 accepts, pulse rst_n low asynchronously -> out_valid=0 immediately; then code 45 -> "A" (key K used).
- Corner letters at index 0 (key K, 31): code 42 -> "M"; code 86 -> "Z"; code 41 -> diff 10 -> "?", out_err=1.
